// File: rtl/fifo_sync1.sv
// Parametrised single-clock FIFO with almost-full/almost-empty flags and occupancy count.
// Define FIFO_FWFT_EN to build the first-word-fall-through output stage.
module fifo_sync1 #(
   parameter int unsigned Width_data = 8,
   parameter int unsigned Width_addr = 4,
   parameter int unsigned Afull_thr  = 12,
   parameter int unsigned Aempty_thr = 2
) (
   input  logic                  sys_clk,
   input  logic                  rst,
   input  logic                  fifo_wr_en,
   input  logic [Width_data-1:0] fifo_wr_data,
   output logic                  fifo_full,
   output logic                  fifo_afull,
   output logic                  fifo_wr_err,
   input  logic                  fifo_rd_en,
   output logic [Width_data-1:0] fifo_rd_data,
   output logic                  fifo_empty,
   output logic                  fifo_aempty,
   output logic                  fifo_rd_err,
   output logic [Width_addr:0]   fifo_cnt
);

   localparam int unsigned Depth = 2 ** Width_addr;
   localparam int unsigned Cw    = Width_addr + 1;

   logic [Width_data-1:0] mem [Depth];
   logic [Width_addr-1:0] wr_ptr;
   logic [Width_addr-1:0] rd_ptr;
   logic [Cw-1:0]         cnt;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  mem_we;
   logic                  mem_re;

   // Flags decode straight from the registered count
   assign fifo_cnt    = cnt;
   assign fifo_full   = (cnt == Cw'(Depth));
   assign fifo_afull  = (cnt >= Cw'(Afull_thr));
   assign fifo_aempty = (cnt <= Cw'(Aempty_thr));

   assign wr_acc = fifo_wr_en & ~fifo_full;
   assign rd_acc = fifo_rd_en & ~fifo_empty;

`ifdef FIFO_FWFT_EN
   logic out_valid;
   logic mem_has;
   logic load;
   logic bypass;

   // Words held in memory = cnt minus the presented word
   assign mem_has    = (cnt != Cw'(out_valid));
   assign load       = ~out_valid | rd_acc;
   assign bypass     = load & ~mem_has & wr_acc;
   assign mem_re     = load & mem_has;
   assign mem_we     = wr_acc & ~bypass;
   assign fifo_empty = ~out_valid;

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         out_valid    <= 1'b0;
         fifo_rd_data <= '0;
      end else if (load) begin
         if (mem_has) begin
            fifo_rd_data <= mem[rd_ptr];
            out_valid    <= 1'b1;
         end else if (wr_acc) begin
            fifo_rd_data <= fifo_wr_data;
            out_valid    <= 1'b1;
         end else begin
            out_valid    <= 1'b0;
         end
      end
   end
`else
   assign mem_re     = rd_acc;
   assign mem_we     = wr_acc;
   assign fifo_empty = (cnt == '0);

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         fifo_rd_data <= '0;
      end else if (rd_acc) begin
         fifo_rd_data <= mem[rd_ptr];
      end
   end
`endif

   // Storage array is intentionally not reset
   always_ff @(posedge sys_clk) begin
      if (mem_we) begin
         mem[wr_ptr] <= fifo_wr_data;
      end
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         cnt         <= '0;
         fifo_wr_err <= 1'b0;
         fifo_rd_err <= 1'b0;
      end else begin
         if (mem_we) wr_ptr <= wr_ptr + 1'b1;
         if (mem_re) rd_ptr <= rd_ptr + 1'b1;
         cnt         <= cnt + Cw'(wr_acc) - Cw'(rd_acc);
         fifo_wr_err <= fifo_wr_en & fifo_full;
         fifo_rd_err <= fifo_rd_en & fifo_empty;
      end
   end

endmodule
